tpu_uart_host: RTL and testbench
================================

// Module: tpu_uart_host
// PURPOSE
//  Host-side initiator for the TPU UART command protocol; the mirror of the TPU's UART controller.
//  Accepts one command word, sends opcode + payload bytes to a byte-level UART transmitter.
//  For read commands it collects response bytes from a byte-level UART receiver and returns them as one word.
//  Used in the host FPGA / loopback bench that drives tpu_top over its uart_rx/uart_tx pins.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  idle cycles allowed between response bytes before abort
//  TO_W            20         width of the timeout counter (>= clog2(TIMEOUT_CYCLES+1))
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  cmd_valid     in   1   command request
//  cmd_ready     out  1   high only in IDLE
//  cmd_opcode    in   8   opcode byte (tpu_uart_pkg values)
//  cmd_payload   in   32  payload, right-justified
//  cmd_len       in   3   payload bytes to send, 0..4
//  cmd_rsp_len   in   3   response bytes expected, 0..4
//  tx_byte       out  8   byte to the UART transmitter
//  tx_valid      out  1   tx_byte valid
//  tx_ready      in   1   transmitter accepts (transfer = tx_valid & tx_ready)
//  rx_byte       in   8   byte from the UART receiver
//  rx_valid      in   1   one-cycle strobe, no backpressure
//  rsp_valid     out  1   one-cycle pulse: command finished
//  rsp_data      out  32  response bytes, right-justified; held until the next rsp_valid
//  rsp_nbytes    out  3   response bytes actually received
//  rsp_timeout   out  1   qualifies rsp_valid: response aborted by timeout
//  busy          out  1   state != IDLE
//  stray_rx      out  1   sticky: a byte arrived while not in WAIT_RSP; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; cmd_ready=1; tx_valid=0; tx_byte=0; rsp_*=0; busy=0; stray_rx=0; counters=0.
//  FSM:
//   IDLE -> SEND_OP on cmd_valid. Latch opcode/payload/len/rsp_len; cmd_len>4 and cmd_rsp_len>4 clamp to 4.
//   SEND_OP: tx_valid=1, tx_byte=opcode.
//     On transfer -> SEND_PL if len>0, else WAIT_RSP if rsp_len>0, else DONE.
//   SEND_PL: bytes go MSB-first of the used span: payload[8*len-1 -: 8] first, payload[7:0] last.
//     After the last transfer -> WAIT_RSP if rsp_len>0, else DONE.
//   WAIT_RSP: each rx_valid shifts in: acc = {acc[23:0], rx_byte}; rx count increments.
//     Count == rsp_len -> DONE.
//     Timeout counter clears on entry and on every rx_valid, increments otherwise.
//     Counter reaching TIMEOUT_CYCLES -> DONE with timeout flag set.
//   DONE: one cycle. rsp_valid=1; rsp_data=acc; rsp_nbytes=count; rsp_timeout=flag. -> IDLE.
//  tx_valid and tx_byte stay stable while tx_ready=0. No byte is dropped or repeated.
//  Latency, zero-payload/zero-response command: cmd accept (cycle 0), opcode on tx at cycle 1; if tx_ready=1,
//   transfer at cycle 1, DONE at cycle 2, cmd_ready again at cycle 3.
//  rx_valid outside WAIT_RSP: byte discarded, stray_rx set. In DONE this covers extra bytes beyond rsp_len.
//  rx_valid in the same cycle the timeout would fire: the byte is taken, the counter clears, no timeout.
//  cmd_valid while busy is ignored. Every accepted command yields exactly one rsp_valid.
//  Reset mid-operation aborts the command with no rsp_valid. A byte the transmitter has half-sent is the
//   transmitter's concern.
// STRUCTURE
//  tpu_uart_pkg holds the opcode constants shared with the TPU UART controller:
//   CMD_WEIGHT_COL0=8'h01 (1B), CMD_WEIGHT_COL1=8'h02 (1B), CMD_WF_RESET=8'h03 (0B), CMD_ACT=8'h04 (2B),
//   CMD_START=8'h05 (0B), CMD_READ_STATUS=8'h06 (rsp 4B: state, cycle_cnt, acc0[15:8], acc0[7:0]),
//   CMD_READ_ACC0=8'h07 (rsp 4B).
//  The package also holds the state enum typedef and RSP_MAX_BYTES=4.
//  Single flat module, no sub-module; the byte transceivers are instantiated alongside it by the integrator.
// TESTING
//  1. CMD_ACT, payload 0x0000_A5C3, len 2, rsp 0, tx_ready=1 -> tx sequence 04,A5,C3; one rsp_valid,
//     nbytes 0, timeout 0.
//  2. CMD_READ_ACC0, rsp 4; feed DE,AD,BE,EF spaced 900 cycles -> rsp_data=0xDEADBEEF, nbytes 4, timeout 0.
//  3. tx_ready toggled pseudo-randomly during a 4-byte payload 0x11223344 -> exactly 01/02/.. opcode then
//     11,22,33,44; tx_byte stable while stalled.
//  4. TIMEOUT_CYCLES=100, rsp 4, feed only 0x7F -> rsp_valid at 100 cycles after that byte, rsp_timeout=1,
//     nbytes 1, rsp_data=0x0000007F.
//  5. rx_valid in IDLE, and a 5th byte after a 4-byte response -> stray_rx=1; next command's rsp_data unaffected.
//  6. Assert rst_n low mid-payload -> all outputs at reset values immediately; a new command after release
//     works; no spurious rsp_valid.

Source files
------------

// File: rtl/tpu_uart_pkg.sv
// -----------------------------------------------------------------------------
// tpu_uart_pkg
//   Constants shared between the TPU UART controller and its host-side
//   initiator: command opcodes, the longest response in bytes, the host FSM
//   state type and a length clamp helper.
//
//   Opcode              payload  response
//   CMD_WEIGHT_COL0     1 byte   -
//   CMD_WEIGHT_COL1     1 byte   -
//   CMD_WF_RESET        0 bytes  -
//   CMD_ACT             2 bytes  -
//   CMD_START           0 bytes  -
//   CMD_READ_STATUS     0 bytes  4 bytes: state, cycle_cnt, acc0[15:8], acc0[7:0]
//   CMD_READ_ACC0       0 bytes  4 bytes
// -----------------------------------------------------------------------------
package tpu_uart_pkg;

   localparam logic [7:0] CMD_WEIGHT_COL0 = 8'h01;
   localparam logic [7:0] CMD_WEIGHT_COL1 = 8'h02;
   localparam logic [7:0] CMD_WF_RESET    = 8'h03;
   localparam logic [7:0] CMD_ACT         = 8'h04;
   localparam logic [7:0] CMD_START       = 8'h05;
   localparam logic [7:0] CMD_READ_STATUS = 8'h06;
   localparam logic [7:0] CMD_READ_ACC0   = 8'h07;

   localparam int RSP_MAX_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_OP,
      ST_SEND_PL,
      ST_WAIT_RSP,
      ST_DONE
   } host_state_t;

   // Byte counts above the 32-bit word size saturate at four bytes.
   function automatic logic [2:0] clamp_len(input logic [2:0] n);
      return (n > 3'(RSP_MAX_BYTES)) ? 3'(RSP_MAX_BYTES) : n;
   endfunction

endpackage

// File: rtl/tpu_uart_host.sv
// -----------------------------------------------------------------------------
// tpu_uart_host
//   Host-side initiator for the TPU UART command protocol. Takes one command
//   word, sends the opcode and then the payload bytes (most significant used
//   byte first) to a byte transmitter, then for read commands gathers the
//   response bytes from a byte receiver into one right-justified word.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (ready only while idle)
//   cmd_opcode              opcode byte
//   cmd_payload             payload, right-justified
//   cmd_len, cmd_rsp_len    payload / response byte counts (clamped to 4)
//   tx_byte, tx_valid       byte to the transmitter, held while tx_ready=0
//   tx_ready                transmitter accepts the byte
//   rx_byte, rx_valid       received byte strobe, no backpressure
//   rsp_valid               one-cycle pulse per accepted command
//   rsp_data, rsp_nbytes    response word and byte count, held between pulses
//   rsp_timeout             response aborted after too long a gap
//   busy                    command in progress
//   stray_rx                sticky: a byte arrived when none was expected
// -----------------------------------------------------------------------------
module tpu_uart_host
   import tpu_uart_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int TO_W           = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_opcode,
   input  logic [31:0] cmd_payload,
   input  logic [2:0]  cmd_len,
   input  logic [2:0]  cmd_rsp_len,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic [2:0]  rsp_nbytes,
   output logic        rsp_timeout,
   output logic        busy,
   output logic        stray_rx
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   host_state_t     state, state_nxt;
   logic [7:0]      opcode_r;
   logic [31:0]     pl_sr;       // payload left-aligned; next byte in [31:24]
   logic [2:0]      pl_left;
   logic [2:0]      rsp_len_r;
   logic [31:0]     acc;
   logic [2:0]      rx_cnt;
   logic [TO_W-1:0] to_cnt;
   logic            rx_take;
   logic            timeout_hit;
   logic [2:0]      len_c;
   logic [2:0]      rx_cnt_inc;
   logic [31:0]     acc_shift;

   assign len_c      = clamp_len(cmd_len);
   assign rx_cnt_inc = rx_cnt + 3'd1;
   assign acc_shift  = {acc[23:0], rx_byte};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      cmd_ready   = 1'b0;
      tx_valid    = 1'b0;
      tx_byte     = 8'h00;
      rsp_valid   = 1'b0;
      busy        = (state != ST_IDLE);
      rx_take     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = ST_SEND_OP;
         end
         ST_SEND_OP: begin
            tx_valid = 1'b1;
            tx_byte  = opcode_r;
            if (tx_ready) begin
               if (pl_left != 3'd0)        state_nxt = ST_SEND_PL;
               else if (rsp_len_r != 3'd0) state_nxt = ST_WAIT_RSP;
               else                        state_nxt = ST_DONE;
            end
         end
         ST_SEND_PL: begin
            tx_valid = 1'b1;
            tx_byte  = pl_sr[31:24];
            if (tx_ready && pl_left == 3'd1)
               state_nxt = (rsp_len_r != 3'd0) ? ST_WAIT_RSP : ST_DONE;
         end
         ST_WAIT_RSP: begin
            // A byte in the cycle the timeout would fire wins over the timeout.
            if (rx_valid) begin
               rx_take = 1'b1;
               if (rx_cnt_inc == rsp_len_r) state_nxt = ST_DONE;
            end else if (to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = ST_DONE;
            end
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_r    <= 8'h00;
         pl_sr       <= 32'h0;
         pl_left     <= 3'd0;
         rsp_len_r   <= 3'd0;
         acc         <= 32'h0;
         rx_cnt      <= 3'd0;
         to_cnt      <= '0;
         rsp_data    <= 32'h0;
         rsp_nbytes  <= 3'd0;
         rsp_timeout <= 1'b0;
         stray_rx    <= 1'b0;
      end else begin
         if (state == ST_IDLE && cmd_valid) begin
            opcode_r  <= cmd_opcode;
            pl_left   <= len_c;
            rsp_len_r <= clamp_len(cmd_rsp_len);
            acc       <= 32'h0;
            rx_cnt    <= 3'd0;
            to_cnt    <= '0;
            case (len_c)
               3'd1:    pl_sr <= {cmd_payload[7:0], 24'h0};
               3'd2:    pl_sr <= {cmd_payload[15:0], 16'h0};
               3'd3:    pl_sr <= {cmd_payload[23:0], 8'h0};
               default: pl_sr <= cmd_payload;
            endcase
         end
         if (state == ST_SEND_PL && tx_ready) begin
            pl_sr   <= {pl_sr[23:0], 8'h00};
            pl_left <= pl_left - 3'd1;
         end
         if (state == ST_WAIT_RSP) begin
            if (rx_take) begin
               acc    <= acc_shift;
               rx_cnt <= rx_cnt_inc;
               to_cnt <= '0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
         // Capture the result as DONE is entered, including a final byte taken
         // in the same cycle, so it is visible alongside rsp_valid.
         if (state_nxt == ST_DONE) begin
            rsp_data    <= rx_take ? acc_shift : acc;
            rsp_nbytes  <= rx_take ? rx_cnt_inc : rx_cnt;
            rsp_timeout <= timeout_hit;
         end
         if (rx_valid && state != ST_WAIT_RSP) stray_rx <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tpu_uart_host.sv
module tb_tpu_uart_host;
   import tpu_uart_pkg::*;

   localparam int TO = 1000;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  n;
      logic        to;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode;
   logic [31:0] cmd_payload;
   logic [2:0]  cmd_len;
   logic [2:0]  cmd_rsp_len;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [2:0]  rsp_nbytes;
   logic        rsp_timeout;
   logic        busy;
   logic        stray_rx;

   tpu_uart_host #(.TIMEOUT_CYCLES(TO), .TO_W(20)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_payload(cmd_payload), .cmd_len(cmd_len), .cmd_rsp_len(cmd_rsp_len),
      .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_byte(rx_byte), .rx_valid(rx_valid),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nbytes(rsp_nbytes),
      .rsp_timeout(rsp_timeout), .busy(busy), .stray_rx(stray_rx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_tx[$];
   rsp_t        exp_rsp[$];
   rsp_t        e_r;
   int          rsp_cyc = 0;
   int          t_acc = 0;
   int          last_rx_cyc = 0;
   bit          rdy_rand = 1'b0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_byte = 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Transmit side: every transfer must match the next expected byte, and a
   // stalled byte must not change or vanish.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            chk("tx_hold_valid", 32'(tx_valid), 32'd1);
            chk("tx_hold_byte", 32'(tx_byte), 32'(prev_byte));
         end
         if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) chk("tx_extra_byte", 32'(exp_tx.size()), 32'd1);
            else                    chk("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
         end
         prev_stall <= tx_valid && !tx_ready;
         prev_byte  <= tx_byte;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   // Response side: one expected entry per rsp_valid pulse.
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         rsp_cyc <= cyc;
         if (exp_rsp.size() == 0) begin
            chk("rsp_extra", 32'(exp_rsp.size()), 32'd1);
         end else begin
            e_r = exp_rsp.pop_front();
            chk("rsp_data", rsp_data, e_r.data);
            chk("rsp_nbytes", 32'(rsp_nbytes), 32'(e_r.n));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e_r.to));
         end
      end
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rx(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid    = 1'b0;
      last_rx_cyc = cyc;
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [31:0] pl,
                           input logic [2:0] len, input logic [2:0] rlen, input rsp_t e);
      int k = 0;
      int n;
      while (!cmd_ready && k < 5000) begin
         idle(1);
         k++;
      end
      if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_opcode  = op;
      cmd_payload = pl;
      cmd_len     = len;
      cmd_rsp_len = rlen;
      cmd_valid   = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      t_acc     = cyc;
      exp_tx.push_back(op);
      n = (len > 3'd4) ? 4 : int'(len);
      for (int i = n - 1; i >= 0; i--) exp_tx.push_back(pl[8*i +: 8]);
      exp_rsp.push_back(e);
   endtask

   task automatic wait_done(input int bound);
      int k = 0;
      while ((exp_tx.size() != 0 || exp_rsp.size() != 0) && k < bound) begin
         idle(1);
         k++;
      end
      if (exp_tx.size() != 0 || exp_rsp.size() != 0) begin
         chk("wait_done", 32'(exp_tx.size() + exp_rsp.size()), 32'd0);
         exp_tx.delete();
         exp_rsp.delete();
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_opcode  = 8'h00;
      cmd_payload = 32'h0;
      cmd_len     = 3'd0;
      cmd_rsp_len = 3'd0;
      rx_byte     = 8'h00;
      rx_valid    = 1'b0;
      idle(3);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_byte", 32'(tx_byte), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stray", 32'(stray_rx), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Two-byte payload, no response.
      send_cmd(CMD_ACT, 32'h0000_A5C3, 3'd2, 3'd0, '{32'h0, 3'd0, 1'b0});
      wait_done(50);

      // Zero-payload, zero-response latency: DONE in cycle 2, ready in cycle 3.
      send_cmd(CMD_START, 32'h0, 3'd0, 3'd0, '{32'h0, 3'd0, 1'b0});
      chk("lat_c1_busy", 32'(busy), 32'd1);
      idle(1);
      chk("lat_c2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("lat_c2_cmd_ready", 32'(cmd_ready), 32'd0);
      idle(1);
      chk("lat_c3_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("lat_c3_rsp_valid", 32'(rsp_valid), 32'd0);
      wait_done(10);

      // Four response bytes with long gaps still below the timeout.
      send_cmd(CMD_READ_ACC0, 32'h0, 3'd0, 3'd4, '{32'hDEAD_BEEF, 3'd4, 1'b0});
      idle(900); rx(8'hDE);
      idle(900); rx(8'hAD);
      idle(900); rx(8'hBE);
      idle(900); rx(8'hEF);
      wait_done(20);

      // Pseudo-random transmitter stalls; a payload length of 5 clamps to 4.
      rdy_rand = 1'b1;
      send_cmd(CMD_WEIGHT_COL1, 32'h1122_3344, 3'd4, 3'd0, '{32'h0, 3'd0, 1'b0});
      wait_done(400);
      send_cmd(CMD_WEIGHT_COL0, 32'hAABB_CCDD, 3'd5, 3'd0, '{32'h0, 3'd0, 1'b0});
      wait_done(400);
      send_cmd(CMD_ACT, 32'h0000_BEEF, 3'd2, 3'd0, '{32'h0, 3'd0, 1'b0});
      wait_done(400);
      rdy_rand = 1'b0;
      idle(3);

      // Timeout after a single byte: abort TO cycles after the byte.
      send_cmd(CMD_READ_ACC0, 32'h0, 3'd0, 3'd4, '{32'h0000_007F, 3'd1, 1'b1});
      idle(3);
      rx(8'h7F);
      wait_done(TO + 50);
      chk("timeout_latency", 32'(rsp_cyc - last_rx_cyc), 32'(TO));

      // A byte in the very cycle the timeout would fire is taken instead.
      send_cmd(CMD_READ_ACC0, 32'h0, 3'd0, 3'd4, '{32'h0000_7F80, 3'd2, 1'b1});
      idle(3);
      rx(8'h7F);
      idle(TO - 1);
      rx(8'h80);
      wait_done(TO + 50);
      chk("timeout_latency_edge", 32'(rsp_cyc - last_rx_cyc), 32'(TO));

      // Extra byte during DONE is stray; response length 7 clamps to 4.
      chk("stray_before", 32'(stray_rx), 32'd0);
      send_cmd(CMD_READ_STATUS, 32'h0, 3'd0, 3'd7, '{32'h0102_0304, 3'd4, 1'b0});
      idle(3);
      rx(8'h01); rx(8'h02); rx(8'h03); rx(8'h04);
      rx(8'h55);
      idle(2);
      chk("stray_done", 32'(stray_rx), 32'd1);
      wait_done(20);
      send_cmd(CMD_READ_ACC0, 32'h0, 3'd0, 3'd2, '{32'h0000_1234, 3'd2, 1'b0});
      idle(3);
      rx(8'h12); rx(8'h34);
      wait_done(20);
      idle(5);
      chk("rsp_data_held", rsp_data, 32'h0000_1234);

      // Reset in the middle of a payload.
      send_cmd(CMD_WEIGHT_COL1, 32'hCAFE_F00D, 3'd4, 3'd0, '{32'h0, 3'd0, 1'b0});
      idle(2);
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_tx_valid", 32'(tx_valid), 32'd0);
      chk("arst_tx_byte", 32'(tx_byte), 32'd0);
      chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rsp_data", rsp_data, 32'd0);
      chk("arst_rsp_nbytes", 32'(rsp_nbytes), 32'd0);
      chk("arst_stray", 32'(stray_rx), 32'd0);
      exp_tx.delete();
      exp_rsp.delete();
      idle(2);
      rst_n = 1'b1;
      idle(2);
      rx(8'h99);
      idle(1);
      chk("stray_idle", 32'(stray_rx), 32'd1);
      send_cmd(CMD_ACT, 32'h0000_1357, 3'd2, 3'd0, '{32'h0, 3'd0, 1'b0});
      wait_done(50);
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
